ex_mem_wb_backend: RTL and testbench
====================================

Name: ex_mem_wb_backend

Overview:
- Back end of the pipelined RV32I core: execute, memory and writeback stages.
- Consumes the registered ID/EX bundle from instruction_decode.
- Returns the redirect pair (PCSrcE, PCtarget) to instruction_fetch and the writeback triple (WB_ID_WE3, WB_ID_RD_A3, WB_ID_WD3) to the decode register file.
- Holds the EX/MEM and MEM/WB pipeline registers and a word-addressed data memory.

Parameters:
- DMEM_DEPTH, 256, data memory size in 32-bit words; power of two.
- DMEM_AW, 8, data memory word-address width; must equal log2(DMEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ID_EX_A / ID_EX_B  in  32 each  rs1 / rs2 operand values
- ID_EX_IMM  in  32  sign-extended immediate
- ID_EX_PC  in  32  PC of the instruction in EX
- ID_EX_RD  in  5  destination register
- alucontrol  in  3  funct3
- alucontrol7  in  7  funct7
- alu_type_sel  in  2  00 arith/logic, 01 address add, 10 branch compare, 11 pass IMM (LUI)
- b_imm_sel  in  1  1: ALU operand B = IMM; with jump=1, marks JALR
- branch, jump, memwrite_en, regwrite_en, wb_sel  in  1 each  control bits; wb_sel 1 = load data
- PCSrcE  out  1  redirect fetch
- PCtarget  out  32  redirect address
- WB_ID_WE3  out  1  register-file write enable
- WB_ID_RD_A3  out  5  write address
- WB_ID_WD3  out  32  write data

Behaviour:
- EX is combinational from the ID_EX_* inputs. opB = b_imm_sel ? IMM : B.
- alu_type_sel 00: funct3 selects ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - SUB only when b_imm_sel=0 and alucontrol7[5]=1.
  - SRA/SRAI when alucontrol7[5]=1.
  - Shift amount = opB[4:0].
- alu_type_sel 01: A+IMM. 11: IMM. 10: ALU result is don't-care.
- Branch condition by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Signed compares are two's complement. Funct3 010/011 never taken.
- PCSrcE = jump | (branch & cond), combinational, same cycle as EX.
- PCtarget:
  - jump & b_imm_sel (JALR): (A+IMM) with bit0 cleared.
  - otherwise: PC+IMM, 32-bit wrap-around.
- EX/MEM register captures result, B, PC+4, RD, regwrite_en, memwrite_en, wb_sel, jump.
- MEM stage:
  - Word address = result[DMEM_AW+1:2]. Upper bits and byte offset are ignored; accesses are word-only (LW/SW).
  - Store writes B on the rising edge when memwrite_en=1.
  - Read is asynchronous; it is registered into MEM/WB.
  - Load from the address being stored in the same cycle returns the old word.
- MEM/WB register captures load data, result, PC+4, RD, regwrite_en, wb_sel, jump.
- WB_ID_WD3 = jump ? PC+4 : (wb_sel ? load : result).
- WB_ID_WE3 = regwrite_en & (RD != 0).
- Latency: an instruction in EX at cycle n drives WB_ID_* during cycle n+2, after the second rising edge.
- No forwarding and no stalls; software inserts NOPs. Flushing the wrong-path instruction is done upstream; the back end executes whatever the ID/EX bundle carries.
- Reset: async assert, synchronous-safe deassert on clk.
  - All EX/MEM and MEM/WB fields go to 0. WB_ID_WE3=0, WB_ID_RD_A3=0, WB_ID_WD3=0.
  - Memory contents are not cleared.
  - A store whose rst asserts before its clock edge does not commit.
  - PCSrcE/PCtarget follow the inputs during reset.

Decomposition:
- Shared package rv32i_pkg:
  - alu_type_sel codes.
  - funct3 ALU and branch codes.
  - funct7 bit-5 index.
- One sub-module, rv32i_alu: combinational; opA, opB, funct3, alt bit, type → result, branch cond.
- Data memory is inline.

Test Plan:
- ADD A=5, B=7, funct3=000, alu_type_sel=00, regwrite_en=1, RD=3 → two edges later WB_ID_WE3=1, RD_A3=3, WD3=12.
- SUB A=5, B=7, alucontrol7=0100000 → WD3=32'hFFFFFFFE. Then SRAI A=32'h80000000, IMM=4, b_imm_sel=1 → 32'hF8000000.
- SW A=0x10, IMM=4, B=0xDEADBEEF, then LW same address with wb_sel=1, RD=5 → WD3=0xDEADBEEF. Store cycle shows WE3=0.
- BLT A=-1, B=1, PC=0x40, IMM=0x20 → PCSrcE=1, PCtarget=0x60 the same cycle. BLTU same operands → PCSrcE=0.
- JALR A=0x101, IMM=2, b_imm_sel=1, jump=1, RD=1, PC=0x80 → PCtarget=0x102, WD3=0x84. RD=0 variant → WE3=0.
- Assert rst mid-stream with a load in MEM → WE3/RD_A3/WD3 drop to 0 immediately. Stored words persist after rst deasserts.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I back-end definitions: ALU type codes, funct3 codes, pipeline register layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

   // alu_type_sel encodings
   localparam logic [1:0] TYPE_ALU  = 2'b00;
   localparam logic [1:0] TYPE_ADDR = 2'b01;
   localparam logic [1:0] TYPE_BR   = 2'b10;
   localparam logic [1:0] TYPE_LUI  = 2'b11;

   // funct3 ALU operations
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // funct3 branch conditions
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   // funct7 bit selecting SUB / SRA
   localparam int F7_ALT_BIT = 5;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] b;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memwrite;
      logic        wb_sel;
      logic        jump;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] load;
      logic [31:0] result;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        regwrite;
      logic        wb_sel;
      logic        jump;
   } mem_wb_t;

endpackage

// File: rtl/rv32i_alu.sv
// RV32I execute ALU and branch comparator.
// Latency: combinational. Backpressure: none.
// Ports: op_a/op_b operands, cmp_b rs2 for compares, imm, funct3, alt (funct7[5]),
//        op_b_is_imm, alu_type -> result, cond.
module rv32i_alu
   import rv32i_pkg::*;
(
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] cmp_b,
   input  logic [31:0] imm,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic        op_b_is_imm,
   input  logic [1:0]  alu_type,
   output logic [31:0] result,
   output logic        cond
);

   logic [4:0] shamt;
   assign shamt = op_b[4:0];

   always_comb begin
      result = '0;
      case (alu_type)
         TYPE_ALU: begin
            case (funct3)
               // I-type ADDI carries immediate bits in funct7, so alt only means SUB for R-type
               F3_ADD:  result = (alt && !op_b_is_imm) ? (op_a - op_b) : (op_a + op_b);
               F3_SLL:  result = op_a << shamt;
               F3_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
               F3_SLTU: result = {31'd0, op_a < op_b};
               F3_XOR:  result = op_a ^ op_b;
               F3_SR:   result = alt ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
               F3_OR:   result = op_a | op_b;
               default: result = op_a & op_b;
            endcase
         end
         TYPE_ADDR: result = op_a + imm;
         TYPE_LUI:  result = imm;
         default:   result = '0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (funct3)
         BR_EQ:   cond = (op_a == cmp_b);
         BR_NE:   cond = (op_a != cmp_b);
         BR_LT:   cond = ($signed(op_a) <  $signed(cmp_b));
         BR_GE:   cond = ($signed(op_a) >= $signed(cmp_b));
         BR_LTU:  cond = (op_a <  cmp_b);
         BR_GEU:  cond = (op_a >= cmp_b);
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_wb_backend.sv
// RV32I back end: EX (comb redirect), EX/MEM and MEM/WB registers, word-addressed data memory.
// Latency: redirect same cycle as EX; writeback triple two rising edges after EX.
// Backpressure: none; no stalls or forwarding, the ID/EX bundle is executed as presented.
module ex_mem_wb_backend
   import rv32i_pkg::*;
#(
   parameter int DMEM_DEPTH = 256,
   parameter int DMEM_AW    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ID_EX_A,
   input  logic [31:0] ID_EX_B,
   input  logic [31:0] ID_EX_IMM,
   input  logic [31:0] ID_EX_PC,
   input  logic [4:0]  ID_EX_RD,
   input  logic [2:0]  alucontrol,
   input  logic [6:0]  alucontrol7,
   input  logic [1:0]  alu_type_sel,
   input  logic        b_imm_sel,
   input  logic        branch,
   input  logic        jump,
   input  logic        memwrite_en,
   input  logic        regwrite_en,
   input  logic        wb_sel,
   output logic        PCSrcE,
   output logic [31:0] PCtarget,
   output logic        WB_ID_WE3,
   output logic [4:0]  WB_ID_RD_A3,
   output logic [31:0] WB_ID_WD3
);

   // Reset asserts asynchronously but releases two clocks later, aligned to clk
   logic rst_meta, rst_sync;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // ---------------- EX ----------------
   logic [31:0] op_b, alu_result, jalr_sum;
   logic        br_cond;
   logic        unused_f7;

   assign op_b      = b_imm_sel ? ID_EX_IMM : ID_EX_B;
   assign unused_f7 = ^{alucontrol7[6], alucontrol7[4:0]};

   rv32i_alu u_alu (
      .op_a        (ID_EX_A),
      .op_b        (op_b),
      .cmp_b       (ID_EX_B),
      .imm         (ID_EX_IMM),
      .funct3      (alucontrol),
      .alt         (alucontrol7[F7_ALT_BIT]),
      .op_b_is_imm (b_imm_sel),
      .alu_type    (alu_type_sel),
      .result      (alu_result),
      .cond        (br_cond)
   );

   assign jalr_sum = ID_EX_A + ID_EX_IMM;
   assign PCSrcE   = jump | (branch & br_cond);
   assign PCtarget = (jump && b_imm_sel) ? {jalr_sum[31:1], 1'b0} : (ID_EX_PC + ID_EX_IMM);

   // ---------------- EX/MEM ----------------
   ex_mem_t exm;
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         exm <= '0;
      end else begin
         exm.result   <= alu_result;
         exm.b        <= ID_EX_B;
         exm.pc4      <= ID_EX_PC + 32'd4;
         exm.rd       <= ID_EX_RD;
         exm.regwrite <= regwrite_en;
         exm.memwrite <= memwrite_en;
         exm.wb_sel   <= wb_sel;
         exm.jump     <= jump;
      end
   end

   // ---------------- MEM ----------------
   // Contents survive reset; a pending store is dropped because exm.memwrite clears asynchronously.
   logic [31:0]        dmem [DMEM_DEPTH];
   logic [DMEM_AW-1:0] dmem_addr;
   logic [31:0]        load_data;

   assign dmem_addr = exm.result[DMEM_AW+1:2];
   assign load_data = dmem[dmem_addr];

   always_ff @(posedge clk) begin
      if (exm.memwrite) begin
         dmem[dmem_addr] <= exm.b;
      end
   end

   // ---------------- MEM/WB ----------------
   mem_wb_t mwb;
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         mwb <= '0;
      end else begin
         mwb.load     <= load_data;
         mwb.result   <= exm.result;
         mwb.pc4      <= exm.pc4;
         mwb.rd       <= exm.rd;
         mwb.regwrite <= exm.regwrite;
         mwb.wb_sel   <= exm.wb_sel;
         mwb.jump     <= exm.jump;
      end
   end

   // ---------------- WB ----------------
   assign WB_ID_WE3   = mwb.regwrite & (mwb.rd != 5'd0);
   assign WB_ID_RD_A3 = mwb.rd;
   assign WB_ID_WD3   = mwb.jump ? mwb.pc4 : (mwb.wb_sel ? mwb.load : mwb.result);

endmodule

// File: tb/tb_ex_mem_wb_backend.sv
module tb_ex_mem_wb_backend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC;
   logic [4:0]  ID_EX_RD;
   logic [2:0]  alucontrol;
   logic [6:0]  alucontrol7;
   logic [1:0]  alu_type_sel;
   logic        b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel;
   logic        PCSrcE;
   logic [31:0] PCtarget;
   logic        WB_ID_WE3;
   logic [4:0]  WB_ID_RD_A3;
   logic [31:0] WB_ID_WD3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_mem_wb_backend #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
      .clk(clk), .rst(rst),
      .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_IMM(ID_EX_IMM), .ID_EX_PC(ID_EX_PC),
      .ID_EX_RD(ID_EX_RD), .alucontrol(alucontrol), .alucontrol7(alucontrol7),
      .alu_type_sel(alu_type_sel), .b_imm_sel(b_imm_sel), .branch(branch), .jump(jump),
      .memwrite_en(memwrite_en), .regwrite_en(regwrite_en), .wb_sel(wb_sel),
      .PCSrcE(PCSrcE), .PCtarget(PCtarget),
      .WB_ID_WE3(WB_ID_WE3), .WB_ID_RD_A3(WB_ID_RD_A3), .WB_ID_WD3(WB_ID_WD3)
   );

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic nop();
      ID_EX_A = '0; ID_EX_B = '0; ID_EX_IMM = '0; ID_EX_PC = '0; ID_EX_RD = '0;
      alucontrol = '0; alucontrol7 = '0; alu_type_sel = '0;
      b_imm_sel = 0; branch = 0; jump = 0; memwrite_en = 0; regwrite_en = 0; wb_sel = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // current bundle is captured by one edge, then a NOP follows; outputs sampled after the second edge
   task automatic run2();
      tick();
      nop();
      tick();
   endtask

   task automatic chk_wb(input string name, input logic we, input logic [4:0] rd, input logic [31:0] wd);
      checks++;
      if (WB_ID_WE3 !== we || WB_ID_RD_A3 !== rd || WB_ID_WD3 !== wd) begin
         failures++;
         $display("FAIL %s got we=%b rd=%0d wd=%h exp we=%b rd=%0d wd=%h",
                  name, WB_ID_WE3, WB_ID_RD_A3, WB_ID_WD3, we, rd, wd);
      end
   endtask

   task automatic test_reset();
      nop();
      #2 rst = 1'b0;
      #1;
      chk_wb("reset_outputs", 1'b0, 5'd0, 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick(); tick();
      chk_wb("after_reset_release", 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_alu();
      nop(); ID_EX_A = 32'd5; ID_EX_B = 32'd7; ID_EX_RD = 5'd3; regwrite_en = 1;
      run2();
      chk_wb("add", 1'b1, 5'd3, 32'd12);

      nop(); ID_EX_A = 32'd5; ID_EX_B = 32'd7; ID_EX_RD = 5'd4; regwrite_en = 1; alucontrol7 = 7'b0100000;
      run2();
      chk_wb("sub", 1'b1, 5'd4, 32'hFFFFFFFE);

      // ADDI whose immediate sets funct7[5] must still add
      nop(); ID_EX_A = 32'd5; ID_EX_IMM = 32'd7; b_imm_sel = 1; ID_EX_RD = 5'd4; regwrite_en = 1;
      alucontrol7 = 7'b0100000;
      run2();
      chk_wb("addi_alt", 1'b1, 5'd4, 32'd12);

      nop(); ID_EX_A = 32'h80000000; ID_EX_IMM = 32'd4; b_imm_sel = 1; alucontrol = 3'b101;
      alucontrol7 = 7'b0100000; ID_EX_RD = 5'd6; regwrite_en = 1;
      run2();
      chk_wb("srai", 1'b1, 5'd6, 32'hF8000000);

      nop(); ID_EX_A = 32'h80000000; ID_EX_IMM = 32'd4; b_imm_sel = 1; alucontrol = 3'b101;
      ID_EX_RD = 5'd6; regwrite_en = 1;
      run2();
      chk_wb("srli", 1'b1, 5'd6, 32'h08000000);

      nop(); ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1; alucontrol = 3'b010; ID_EX_RD = 5'd7; regwrite_en = 1;
      run2();
      chk_wb("slt", 1'b1, 5'd7, 32'd1);

      nop(); ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1; alucontrol = 3'b011; ID_EX_RD = 5'd7; regwrite_en = 1;
      run2();
      chk_wb("sltu", 1'b1, 5'd7, 32'd0);

      nop(); ID_EX_A = 32'h0000FF00; ID_EX_B = 32'h00FF0F00; alucontrol = 3'b100; ID_EX_RD = 5'd8; regwrite_en = 1;
      run2();
      chk_wb("xor", 1'b1, 5'd8, 32'h00FFF000);

      nop(); ID_EX_A = 32'hDEAD0000; ID_EX_IMM = 32'h12345000; alu_type_sel = 2'b11; ID_EX_RD = 5'd9; regwrite_en = 1;
      run2();
      chk_wb("lui", 1'b1, 5'd9, 32'h12345000);
   endtask

   task automatic test_mem();
      nop(); ID_EX_A = 32'h10; ID_EX_IMM = 32'd4; b_imm_sel = 1; alu_type_sel = 2'b01;
      ID_EX_B = 32'hDEADBEEF; memwrite_en = 1;
      run2();
      chk_wb("sw_no_write", 1'b0, 5'd0, 32'h14);

      nop(); ID_EX_A = 32'h10; ID_EX_IMM = 32'd4; b_imm_sel = 1; alu_type_sel = 2'b01;
      wb_sel = 1; regwrite_en = 1; ID_EX_RD = 5'd5;
      run2();
      chk_wb("lw", 1'b1, 5'd5, 32'hDEADBEEF);

      // address bits above the word index are ignored: 0x414 aliases word 5
      nop(); ID_EX_A = 32'h410; ID_EX_IMM = 32'd4; b_imm_sel = 1; alu_type_sel = 2'b01;
      wb_sel = 1; regwrite_en = 1; ID_EX_RD = 5'd10;
      run2();
      chk_wb("lw_alias", 1'b1, 5'd10, 32'hDEADBEEF);

      nop(); ID_EX_A = 32'h20; alu_type_sel = 2'b01; ID_EX_B = 32'hAAAAAAAA; memwrite_en = 1;
      run2();
   endtask

   task automatic test_branch();
      nop(); ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1; ID_EX_PC = 32'h40; ID_EX_IMM = 32'h20;
      branch = 1; alucontrol = 3'b100; alu_type_sel = 2'b10;
      #1;
      checks++;
      if (PCSrcE !== 1'b1 || PCtarget !== 32'h60) begin
         failures++;
         $display("FAIL blt got src=%b tgt=%h exp src=1 tgt=00000060", PCSrcE, PCtarget);
      end
      alucontrol = 3'b110;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         failures++;
         $display("FAIL bltu got src=%b exp src=0", PCSrcE);
      end
      alucontrol = 3'b101;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         failures++;
         $display("FAIL bge got src=%b exp src=0", PCSrcE);
      end
      ID_EX_B = 32'hFFFFFFFF; alucontrol = 3'b000;
      #1;
      checks++;
      if (PCSrcE !== 1'b1) begin
         failures++;
         $display("FAIL beq got src=%b exp src=1", PCSrcE);
      end
      alucontrol = 3'b010;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         failures++;
         $display("FAIL br_f3_010 got src=%b exp src=0", PCSrcE);
      end
      alucontrol = 3'b000; branch = 0;
      #1;
      checks++;
      if (PCSrcE !== 1'b0) begin
         failures++;
         $display("FAIL no_branch got src=%b exp src=0", PCSrcE);
      end
      nop();
      tick();
   endtask

   task automatic test_jump();
      nop(); ID_EX_A = 32'h101; ID_EX_IMM = 32'd2; b_imm_sel = 1; jump = 1; ID_EX_RD = 5'd1;
      ID_EX_PC = 32'h80; regwrite_en = 1; alu_type_sel = 2'b01;
      #1;
      checks++;
      if (PCSrcE !== 1'b1 || PCtarget !== 32'h102) begin
         failures++;
         $display("FAIL jalr_tgt got src=%b tgt=%h exp src=1 tgt=00000102", PCSrcE, PCtarget);
      end
      run2();
      chk_wb("jalr_link", 1'b1, 5'd1, 32'h84);

      nop(); ID_EX_A = 32'h101; ID_EX_IMM = 32'd2; b_imm_sel = 1; jump = 1; ID_EX_RD = 5'd0;
      ID_EX_PC = 32'h80; regwrite_en = 1; alu_type_sel = 2'b01;
      run2();
      chk_wb("jalr_rd0", 1'b0, 5'd0, 32'h84);

      // JAL: PC-relative target
      nop(); ID_EX_A = 32'h101; ID_EX_IMM = 32'hFFFFFFF0; jump = 1; ID_EX_PC = 32'h8;
      #1;
      checks++;
      if (PCSrcE !== 1'b1 || PCtarget !== 32'hFFFFFFF8) begin
         failures++;
         $display("FAIL jal_wrap got src=%b tgt=%h exp src=1 tgt=fffffff8", PCSrcE, PCtarget);
      end
      nop();
      tick();
   endtask

   task automatic test_reset_midstream();
      nop(); ID_EX_A = 32'd1; ID_EX_IMM = 32'd2; b_imm_sel = 1; ID_EX_RD = 5'd7; regwrite_en = 1;
      tick();
      nop(); ID_EX_A = 32'h14; alu_type_sel = 2'b01; wb_sel = 1; regwrite_en = 1; ID_EX_RD = 5'd5;
      tick();
      chk_wb("pre_reset", 1'b1, 5'd7, 32'd3);
      // store to word 8 sitting in EX/MEM when reset hits must not commit
      nop(); ID_EX_A = 32'h20; alu_type_sel = 2'b01; ID_EX_B = 32'h11111111; memwrite_en = 1;
      tick();
      nop(); jump = 1; ID_EX_PC = 32'h100; ID_EX_IMM = 32'h10;
      #2 rst = 1'b0;
      #1;
      chk_wb("reset_mid", 1'b0, 5'd0, 32'd0);
      checks++;
      if (PCSrcE !== 1'b1 || PCtarget !== 32'h110) begin
         failures++;
         $display("FAIL reset_redirect got src=%b tgt=%h exp src=1 tgt=00000110", PCSrcE, PCtarget);
      end
      nop();
      tick(); tick();
      rst = 1'b1;
      tick(); tick(); tick();

      nop(); ID_EX_A = 32'h14; alu_type_sel = 2'b01; wb_sel = 1; regwrite_en = 1; ID_EX_RD = 5'd5;
      run2();
      chk_wb("mem_persist", 1'b1, 5'd5, 32'hDEADBEEF);

      nop(); ID_EX_A = 32'h20; alu_type_sel = 2'b01; wb_sel = 1; regwrite_en = 1; ID_EX_RD = 5'd11;
      run2();
      chk_wb("store_dropped", 1'b1, 5'd11, 32'hAAAAAAAA);
   endtask

   task automatic test_back_to_back();
      // consecutive instructions retire on consecutive cycles
      nop(); ID_EX_A = 32'd10; ID_EX_B = 32'd20; ID_EX_RD = 5'd12; regwrite_en = 1;
      tick();
      nop(); ID_EX_A = 32'hF0; ID_EX_B = 32'h3C; alucontrol = 3'b111; ID_EX_RD = 5'd13; regwrite_en = 1;
      tick();
      nop();
      chk_wb("b2b_first", 1'b1, 5'd12, 32'd30);
      tick();
      chk_wb("b2b_second", 1'b1, 5'd13, 32'h30);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_jump();
      test_reset_midstream();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
